// File: rtl/sdram_arb.sv
// sdram_arb: 3-port arbiter in front of a single SDRAM controller port.
// Each grant runs IDLE -> ISSUE -> GUARD -> WAIT -> DONE -> GAP; all outputs
// are registered, so every *_d value describes the state being entered.
// Optional feature: define SDRAM_ARB_RR_EN for round-robin arbitration
// (default build is fixed priority, port 0 highest).
module sdram_arb #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        init,
  input  logic [2:0]  req,
  input  logic [2:0]  req_we,
  input  logic [74:0] req_addr,
  input  logic [23:0] req_din,
  output logic [2:0]  ack,
  output logic [7:0]  rdata,
  output logic        timeout,
  output logic [24:0] mem_addr,
  output logic [7:0]  mem_din,
  output logic        mem_rd,
  output logic        mem_we,
  input  logic [7:0]  mem_dout,
  input  logic        mem_ready
);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_GUARD, S_WAIT, S_DONE, S_GAP} state_t;

  state_t      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic        we_q, we_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [24:0] addr_q, addr_d;
  logic [7:0]  din_q, din_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        rd_q, rd_d, wr_q, wr_d;
  logic [2:0]  ack_q, ack_d;
  logic        to_q, to_d;

  logic        gnt_vld;
  logic [1:0]  gnt_idx;
  logic [24:0] sel_addr;
  logic [7:0]  sel_din;

`ifdef SDRAM_ARB_RR_EN
  // ptr_q is the port searched first; it moves past the winner on each grant.
  logic [1:0] ptr_q, ptr_d;
  logic [2:0] pp;

  // Round-robin search: walk downwards so the closest port to ptr_q wins.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = 2'd0;
    pp      = 3'd0;
    for (int k = 2; k >= 0; k--) begin
      pp = {1'b0, ptr_q} + 3'(k);
      if (pp >= 3'd3) pp = pp - 3'd3;
      if (req[pp[1:0]]) begin
        gnt_vld = 1'b1;
        gnt_idx = pp[1:0];
      end
    end
  end

  // Pointer advances only when a grant is actually taken.
  always_comb begin
    ptr_d = ptr_q;
    if (state_q == S_IDLE && gnt_vld)
      ptr_d = (gnt_idx == 2'd2) ? 2'd0 : gnt_idx + 2'd1;
  end

  // Pointer register.
  always_ff @(posedge clk or posedge init) begin
    if (init) ptr_q <= 2'd0;
    else      ptr_q <= ptr_d;
  end
`else
  // Fixed priority: port 0 > port 1 > port 2.
  always_comb begin
    gnt_vld = |req;
    gnt_idx = req[0] ? 2'd0 : (req[1] ? 2'd1 : 2'd2);
  end
`endif

  // Pick the winner's address/data fields out of the packed port buses.
  always_comb begin
    case (gnt_idx)
      2'd0:    begin sel_addr = req_addr[24:0];  sel_din = req_din[7:0];   end
      2'd1:    begin sel_addr = req_addr[49:25]; sel_din = req_din[15:8];  end
      default: begin sel_addr = req_addr[74:50]; sel_din = req_din[23:16]; end
    endcase
  end

  // Next-state and next-output logic; strobes are high in ISSUE/GUARD/WAIT.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    we_d    = we_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    din_d   = din_q;
    rdata_d = rdata_q;
    to_d    = to_q;
    ack_d   = 3'b000;
    rd_d    = 1'b0;
    wr_d    = 1'b0;
    case (state_q)
      S_IDLE: if (gnt_vld) begin
        idx_d   = gnt_idx;
        we_d    = req_we[gnt_idx];
        addr_d  = sel_addr;
        din_d   = sel_din;
        rd_d    = ~req_we[gnt_idx];
        wr_d    = req_we[gnt_idx];
        state_d = S_ISSUE;
      end
      S_ISSUE: begin
        rd_d    = ~we_q;
        wr_d    = we_q;
        state_d = S_GUARD;
      end
      // mem_ready is not trusted yet: it may still be high from before.
      S_GUARD: begin
        rd_d    = ~we_q;
        wr_d    = we_q;
        cnt_d   = 8'd0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (mem_ready) begin
          if (!we_q) rdata_d = mem_dout;
          ack_d[idx_q] = 1'b1;
          state_d      = S_DONE;
        end else if (cnt_q == 8'(TIMEOUT - 1)) begin
          rdata_d      = 8'hFF;
          to_d         = 1'b1;
          ack_d[idx_q] = 1'b1;
          state_d      = S_DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
          rd_d  = ~we_q;
          wr_d  = we_q;
        end
      end
      S_DONE:  state_d = S_GAP;
      S_GAP:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; init aborts any transaction in flight.
  always_ff @(posedge clk or posedge init) begin
    if (init) begin
      state_q <= S_IDLE;
      idx_q   <= 2'd0;
      we_q    <= 1'b0;
      cnt_q   <= 8'd0;
      addr_q  <= 25'd0;
      din_q   <= 8'd0;
      rdata_q <= 8'd0;
      to_q    <= 1'b0;
      ack_q   <= 3'b000;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      we_q    <= we_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      rdata_q <= rdata_d;
      to_q    <= to_d;
      ack_q   <= ack_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
    end
  end

  assign ack      = ack_q;
  assign rdata    = rdata_q;
  assign timeout  = to_q;
  assign mem_addr = addr_q;
  assign mem_din  = din_q;
  assign mem_rd   = rd_q;
  assign mem_we   = wr_q;

endmodule

// File: tb/tb_sdram_arb.sv
// Directed bench for sdram_arb (TIMEOUT=8). Cycle 0 is the IDLE cycle in
// which req is first seen; outputs are sampled 1 time unit after each edge.
module tb_sdram_arb;

  logic        clk = 1'b0;
  logic        init;
  logic [2:0]  req, req_we;
  logic [74:0] req_addr;
  logic [23:0] req_din;
  logic [2:0]  ack;
  logic [7:0]  rdata;
  logic        timeout;
  logic [24:0] mem_addr;
  logic [7:0]  mem_din;
  logic        mem_rd, mem_we;
  logic [7:0]  mem_dout;
  logic        mem_ready;

  int n_chk  = 0;
  int n_fail = 0;
  int ack_cnt [3] = '{0, 0, 0};

  sdram_arb #(.TIMEOUT(8)) dut (
    .clk(clk), .init(init), .req(req), .req_we(req_we), .req_addr(req_addr),
    .req_din(req_din), .ack(ack), .rdata(rdata), .timeout(timeout),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_rd(mem_rd), .mem_we(mem_we),
    .mem_dout(mem_dout), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  // Count every ack pulse per port, sampled mid-cycle.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) if (ack[i] === 1'b1) ack_cnt[i]++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One transaction on `port`. Controller model: ready high in cycles 0..1,
  // low for `low` cycles from cycle 2, then high with mem_dout=dout.
  // `pulse` >= 0 raises req[pulse] in cycle 2 and drops it in cycle 5.
  // `perturb` corrupts the port's fields from cycle 2 on.
  task automatic txn(input int port, input logic we, input logic [24:0] addr,
                     input logic [7:0] din, input int low, input logic [7:0] dout,
                     input logic [7:0] exp_rd, input bit chk_rd, input int pulse,
                     input bit perturb, input int exp_lat, input string tag);
    int lat = -1;
    int a0 = ack_cnt[port];
    req_we[port] = we;
    req_addr[25*port +: 25] = addr;
    req_din[8*port +: 8] = din;
    req[port] = 1'b1;
    mem_ready = 1'b1;
    mem_dout = dout;
    for (int c = 1; c <= 40 && lat < 0; c++) begin
      step();
      mem_ready = (c >= 2 && c <= 1 + low) ? 1'b0 : 1'b1;
      if (pulse >= 0 && c == 2) req[pulse] = 1'b1;
      if (pulse >= 0 && c == 5) req[pulse] = 1'b0;
      if (perturb && c == 2) begin
        req_addr[25*port +: 25] = ~addr;
        req_din[8*port +: 8] = ~din;
        req_we[port] = ~we;
      end
      if (ack !== 3'b000) begin
        lat = c;
        chk({tag, " ack"}, 32'(ack), 32'(3'b001 << port));
        chk({tag, " strobes low in DONE"}, {30'd0, mem_rd, mem_we}, 32'd0);
        chk({tag, " addr in DONE"}, 32'(mem_addr), 32'(addr));
        if (chk_rd) chk({tag, " rdata"}, 32'(rdata), 32'(exp_rd));
      end else if (mem_rd !== ~we || mem_we !== we || mem_addr !== addr || mem_din !== din) begin
        chk({tag, " strobe/addr/din during ISSUE..WAIT"},
            {5'd0, mem_rd, mem_we, mem_addr}, {5'd0, ~we, we, addr});
      end
    end
    chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
    req[port] = 1'b0;
    step();
    chk({tag, " GAP ack/strobes"}, {27'd0, ack, mem_rd, mem_we}, 32'd0);
    chk({tag, " single ack pulse"}, 32'(ack_cnt[port] - a0), 32'd1);
    step();
  endtask

  initial begin
    int a0;
    int grants [$];
    int lowrun;
    int seen_hi;
    int gap_bad;
    init = 1'b1; req = '0; req_we = '0; req_addr = '0; req_din = '0;
    mem_dout = '0; mem_ready = 1'b1;

    // Reset: outputs stay 0 even with a request pending.
    step();
    req = 3'b001;
    step(); step();
    chk("reset outputs", {ack, rdata, timeout, mem_rd, mem_we}, 32'd0);
    chk("reset mem_addr/din", {mem_din, mem_addr[23:0]} | {31'd0, mem_addr[24]}, 32'd0);
    req = 3'b000;
    init = 1'b0;
    step();

    // Single read on port 1 with ready low for 6 cycles -> ack in cycle 9.
    txn(1, 1'b0, 25'h000123, 8'h00, 6, 8'h5A, 8'h5A, 1'b1, -1, 1'b0, 9, "rd_p1");
    chk("rd_p1 other ports silent", 32'(ack_cnt[0] + ack_cnt[2]), 32'd0);

    // Read hit: ready never falls -> minimum latency of 4.
    txn(0, 1'b0, 25'h0ABCDE, 8'h00, 0, 8'h3C, 8'h3C, 1'b1, -1, 1'b0, 4, "hit_p0");

    // Write on port 2 at the top address, fields disturbed mid-flight.
    txn(2, 1'b1, 25'h1FFFFFF, 8'hC3, 2, 8'h00, 8'h00, 1'b0, -1, 1'b1, 5, "wr_p2");
    chk("wr_p2 mem_din held", 32'(mem_din), 32'hC3);

    // Timeout: ready never returns -> 8 WAIT cycles, ack in cycle 11.
    // Port 1 raises and drops its req before it could be granted.
    a0 = ack_cnt[1];
    chk("timeout flag clear before", 32'(timeout), 32'd0);
    txn(0, 1'b0, 25'h000777, 8'h00, 1000, 8'h12, 8'hFF, 1'b1, 1, 1'b0, 11, "tmo_p0");
    chk("timeout flag set", 32'(timeout), 32'd1);
    chk("dropped req not served", 32'(ack_cnt[1] - a0), 32'd0);

    // Timeout flag is sticky across a successful transaction.
    txn(1, 1'b0, 25'h000010, 8'h00, 1, 8'h99, 8'h99, 1'b1, -1, 1'b0, 4, "after_tmo");
    chk("timeout flag sticky", 32'(timeout), 32'd1);

    // All three ports requesting continuously.
    req_we = 3'b000;
    req_addr = {25'h000300, 25'h000200, 25'h000100};
    mem_ready = 1'b1;
    mem_dout = 8'h44;
    req = 3'b111;
    lowrun = 0; seen_hi = 0; gap_bad = 0;
    for (int c = 1; c <= 60 && grants.size() < 4; c++) begin
      step();
      if (ack[0]) grants.push_back(0);
      if (ack[1]) grants.push_back(1);
      if (ack[2]) grants.push_back(2);
      if (mem_rd || mem_we) begin
        if (seen_hi != 0 && lowrun > 0 && lowrun < 2) gap_bad++;
        seen_hi = 1;
        lowrun = 0;
      end else begin
        lowrun++;
      end
    end
    req = 3'b000;
    chk("arb grant count", 32'(grants.size()), 32'd4);
    while (grants.size() < 4) grants.push_back(-1);
    chk("arb grant 0", 32'(grants[0]), 32'd0);
`ifdef SDRAM_ARB_RR_EN
    chk("arb grant 1", 32'(grants[1]), 32'd1);
    chk("arb grant 2", 32'(grants[2]), 32'd2);
    chk("arb grant 3", 32'(grants[3]), 32'd0);
`else
    chk("arb grant 1", 32'(grants[1]), 32'd0);
    chk("arb grant 2", 32'(grants[2]), 32'd0);
    chk("arb grant 3", 32'(grants[3]), 32'd0);
`endif
    chk("arb strobe-low gap >= 2", 32'(gap_bad), 32'd0);
    step(); step(); step();

    // init pulsed during WAIT aborts the transaction with no ack.
    a0 = ack_cnt[0];
    req_we[0] = 1'b0;
    req_addr[24:0] = 25'h000055;
    req[0] = 1'b1;
    mem_ready = 1'b1;
    step(); mem_ready = 1'b0;            // cycle 1
    step(); step(); step(); step();      // cycle 5, in WAIT
    chk("pre-abort mem_rd", 32'(mem_rd), 32'd1);
    init = 1'b1;
    #1;
    chk("abort strobes/ack", {27'd0, ack, mem_rd, mem_we}, 32'd0);
    chk("abort timeout cleared", 32'(timeout), 32'd0);
    chk("abort mem_addr cleared", 32'(mem_addr), 32'd0);
    req[0] = 1'b0;
    step(); step();
    init = 1'b0;
    step(); step();
    chk("abort no ack", 32'(ack_cnt[0] - a0), 32'd0);
    // Back in IDLE: a re-presented request sees minimum latency again.
    txn(0, 1'b0, 25'h000055, 8'h00, 0, 8'h77, 8'h77, 1'b1, -1, 1'b0, 4, "after_abort");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
